// File: rtl/pipe_if_queue.sv
// pipe_if_queue
//   Instruction queue between the IF and ID pipeline stages. Fetched
//   {PC+4, instruction} pairs are buffered in a DEPTH-entry FIFO. ID consumes
//   the head entry when its stall signal (wpcir) allows it. A redirect (flush)
//   discards everything queued and counts the discarded entries.
//
// Parameters
//   IW    - instruction width
//   AW    - PC+4 width
//   DEPTH - entries, power of two in 2..64
//
// Ports
//   clock       in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   f_valid     in   IF presents an instruction
//   f_pc4       in   PC+4 of the fetched instruction
//   f_inst      in   fetched instruction word
//   f_ready     out  queue can accept an instruction (registered state only)
//   d_ready     in   ID consumes the head this cycle
//   d_valid     out  head entry valid
//   d_pc4       out  head PC+4 (zero when empty)
//   d_inst      out  head instruction (zero/NOP when empty)
//   flush       in   discard all queued instructions
//   count       out  occupied entries
//   flush_drops out  saturating count of entries discarded by flushes
module pipe_if_queue #(
  parameter int unsigned IW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     f_valid,
  input  logic [AW-1:0]            f_pc4,
  input  logic [IW-1:0]            f_inst,
  output logic                     f_ready,
  input  logic                     d_ready,
  output logic                     d_valid,
  output logic [AW-1:0]            d_pc4,
  output logic [IW-1:0]            d_inst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               flush_drops
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [IW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] pc4_mem  [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic [8:0]    drop_sum;

  // f_ready comes from the registered count only, so a pop in a full cycle
  // cannot open the queue for a push in that same cycle.
  assign f_ready = (count < FULL_COUNT);
  assign d_valid = (count != '0);

  assign push = f_valid && f_ready && !flush;
  assign pop  = d_valid && d_ready && !flush;

  // Storage is never cleared; masking on d_valid keeps stale data invisible.
  assign d_inst = d_valid ? inst_mem[rd_ptr] : '0;
  assign d_pc4  = d_valid ? pc4_mem[rd_ptr]  : '0;

  // Nine bits hold 255 + 64 without overflow; bit 8 flags saturation.
  assign drop_sum = {1'b0, flush_drops} + 9'(count);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      flush_drops <= '0;
    end else if (flush) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      flush_drops <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end else begin
      // Pointers are exactly PW bits wide, so DEPTH-1 wraps to 0 naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= f_inst;
      pc4_mem[wr_ptr]  <= f_pc4;
    end
  end

endmodule

// File: tb/tb_pipe_if_queue.sv
module tb_pipe_if_queue;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        f_valid = 1'b0;
  logic [31:0] f_pc4 = '0;
  logic [31:0] f_inst = '0;
  logic        f_ready;
  logic        d_ready = 1'b0;
  logic        d_valid;
  logic [31:0] d_pc4;
  logic [31:0] d_inst;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic [7:0]  flush_drops;

  pipe_if_queue #(.IW(32), .AW(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn),
    .f_valid(f_valid), .f_pc4(f_pc4), .f_inst(f_inst), .f_ready(f_ready),
    .d_ready(d_ready), .d_valid(d_valid), .d_pc4(d_pc4), .d_inst(d_inst),
    .flush(flush), .count(count), .flush_drops(flush_drops)
  );

  always #5 clock = ~clock;

  // Reference model: queue of expected {pc4, inst} plus drop counter.
  logic [63:0] exp_q [$];
  int unsigned m_drops = 0;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  bit          mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: samples 2 time units after the falling edge, well away from
  // the rising edge, and consumes the head whenever the DUT hands one off.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (mon_en) begin
        chk("d_valid", 64'(d_valid), 64'(exp_q.size() != 0));
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("f_ready", 64'(f_ready), 64'(exp_q.size() < DEPTH));
        chk("flush_drops", 64'(flush_drops), 64'(m_drops));
        if (exp_q.size() == 0) begin
          chk("empty_out", {d_pc4, d_inst}, 64'h0);
        end else begin
          chk("head", {d_pc4, d_inst}, exp_q[0]);
          if (d_valid && d_ready && !flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus; model update is applied after the monitor ran.
  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic dr, input logic fl);
    int unsigned pre;
    @(negedge clock);
    f_valid = fv; f_pc4 = pc; f_inst = ins; d_ready = dr; flush = fl;
    pre = exp_q.size();
    #3;
    if (fl) begin
      m_drops = (m_drops + pre > 255) ? 255 : m_drops + pre;
      exp_q.delete();
    end else if (fv && pre < DEPTH) begin
      exp_q.push_back({pc, ins});
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 resetn = 1'b1;
    mon_en = 1'b1;

    // Fill with no consumer.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(4 * (i + 1)), 32'(8'h11 * (i + 1)), 1'b0, 1'b0);
    // Blocked push while full must not drop or overwrite anything.
    step(1'b1, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0);
    // Drain in order, plus one underflow attempt.
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Streaming through the pointer wrap.
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'(32'h200 + 4 * i), 32'(32'h100 + i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with 3 queued, simultaneous push and pop attempt.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(i), 32'(32'h300 + i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1);
    idle();
    // Flush while empty.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle();

    // Saturation: flush a full queue many times.
    for (int k = 0; k < 90; k++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 32'(k), 32'(i), 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    idle();

    // Asynchronous reset between edges with two entries queued.
    for (int i = 0; i < 2; i++) step(1'b1, 32'(32'h40 + i), 32'(32'h500 + i), 1'b0, 1'b0);
    @(negedge clock);
    f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0;
    #1;
    resetn = 1'b0;
    exp_q.delete();
    m_drops = 0;
    @(negedge clock);
    #1 resetn = 1'b1;
    step(1'b1, 32'h0000_0044, 32'h0000_0777, 1'b0, 1'b0);
    idle();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    idle();

    mon_en = 1'b0;
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_if_queue.md
PIPE_IF_QUEUE -- requirements
Module: pipe_if_queue

Interface
REQ-001 The block SHALL have parameter IW, default 32: instruction width in bits.
REQ-002 The block SHALL have parameter AW, default 32: PC+4 width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4: queue entries; legal values are powers of two, 2 to 64.
REQ-004 The block SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port f_valid, input, 1: IF stage presents a fetched instruction.
REQ-007 The block SHALL have port f_pc4, input, AW: PC+4 of the fetched instruction.
REQ-008 The block SHALL have port f_inst, input, IW: fetched instruction word.
REQ-009 The block SHALL have port f_ready, output, 1: queue can accept an instruction this cycle.
REQ-010 The block SHALL have port d_ready, input, 1: ID stage consumes the head this cycle (driven from the decoder's wpcir).
REQ-011 The block SHALL have port d_valid, output, 1: head entry valid.
REQ-012 The block SHALL have port d_pc4, output, AW: head PC+4.
REQ-013 The block SHALL have port d_inst, output, IW: head instruction word.
REQ-014 The block SHALL have port flush, input, 1: redirect from branch, jump or jr; discard all queued instructions.
REQ-015 The block SHALL have port count, output, log2(DEPTH)+1: number of occupied entries.
REQ-016 The block SHALL have port flush_drops, output, 8: saturating count of entries discarded by flushes.

Function
REQ-017 A push SHALL occur when f_valid && f_ready && !flush; a pop SHALL occur when d_valid && d_ready && !flush.
REQ-018 f_ready SHALL equal (count < DEPTH), taken from registered state only, with no combinational path from d_ready.
REQ-019 When full, a simultaneous pop SHALL NOT enable a push in the same cycle.
REQ-020 d_valid SHALL equal (count != 0).
REQ-021 When d_valid is 1, d_inst and d_pc4 SHALL show the head entry.
REQ-022 When d_valid is 0, d_inst SHALL be all zeros (a NOP) and d_pc4 SHALL be all zeros.
REQ-023 Latency SHALL be one cycle: an instruction pushed at edge k appears on d_* after edge k when it is the oldest entry. There is no same-cycle bypass.
REQ-024 Order SHALL be strict FIFO.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-026 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-027 On flush, at the next edge count SHALL become 0 and both pointers SHALL reset to 0.
REQ-028 During a flush cycle, any f_valid entry SHALL be discarded and any d_ready SHALL NOT count as a pop.
REQ-029 During a flush cycle, flush_drops SHALL increase by the pre-flush count, saturating at 255.
REQ-030 A flush while empty SHALL leave flush_drops unchanged.
REQ-031 d_ready asserted while d_valid is 0 SHALL have no effect (underflow-safe).
REQ-032 f_valid asserted while f_ready is 0 SHALL have no effect. The producer holds data and retries; the block SHALL NOT drop it or raise an error.

Reset
REQ-033 While resetn is 0, regardless of clock, the block SHALL hold: count=0, pointers=0, d_valid=0, d_inst=0, d_pc4=0, f_ready=1, flush_drops=0.
REQ-034 Storage contents need not be cleared on reset, but they SHALL never be visible while d_valid is 0.
REQ-035 Deasserting resetn mid-operation SHALL discard all queued entries without producing a spurious d_valid pulse.

Verification (DEPTH=4, IW=AW=32)
REQ-036 Fill: push 0x11,0x22,0x33,0x44 (pc4 0x4..0x10) with d_ready=0 -> count=4, f_ready=0, d_inst=0x11, d_pc4=0x4.
REQ-037 Drain order: from full, d_ready=1 for 4 cycles, no pushes -> d_inst 0x11,0x22,0x33,0x44, then d_valid=0, d_inst=0, count=0.
REQ-038 Stream with wrap: f_valid=d_ready=1 for 10 cycles, with inst = 0x100+i -> count stays 1 after the first edge, and outputs are in order with pointers wrapping twice.
REQ-039 Flush: count=3, then flush=1 together with f_valid=1 and d_ready=1 -> next cycle count=0, d_valid=0, flush_drops=3, and the pushed word never appears.
REQ-040 Saturation: 90 flushes of a full queue -> flush_drops=255.
REQ-041 Async reset: assert resetn=0 between clock edges with count=2 -> outputs reach reset values immediately, and after release the first push appears one cycle later.
